// File: rtl/dmem_arbiter.sv
// dmem_arbiter: arbitrates core and debug accesses onto one synchronous-read DMEM port.
// Define DMEM_ARB_STARVE_EN to let debug win after MAX_STARVE contested core wins.
module dmem_arbiter #(
    parameter int AW = 32,
    parameter int DW = 32,
    parameter int MAX_STARVE = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          core_req,
    input  logic          core_we,
    input  logic [AW-1:0] core_addr,
    input  logic [DW-1:0] core_wdata,
    output logic          core_stall,
    output logic          core_rvalid,
    output logic [DW-1:0] core_rdata,
    input  logic          dbg_req,
    input  logic          dbg_we,
    input  logic          dbg_lock,
    input  logic [AW-1:0] dbg_addr,
    input  logic [DW-1:0] dbg_wdata,
    output logic          dbg_gnt,
    output logic          dbg_rvalid,
    output logic [DW-1:0] dbg_rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);
    typedef enum logic {S_CORE, S_DBG} state_t;
    state_t state, state_nxt;
    logic core_acc, dbg_acc, force_dbg, core_rd, dbg_rd;
`ifdef DMEM_ARB_STARVE_EN
    localparam int SW = MAX_STARVE > 0 ? $clog2(MAX_STARVE + 1) : 1;
    logic [SW-1:0] starve_cnt;
    assign force_dbg = starve_cnt == SW'(MAX_STARVE);
    always_ff @(posedge clk) begin
        if (!rst_n || dbg_acc || !dbg_req)
            starve_cnt <= '0;
        else if (core_acc && !force_dbg)
            starve_cnt <= starve_cnt + 1'b1;
    end
`else
    assign force_dbg = 1'b0;
`endif
    // A locked burst keeps the port; otherwise core has priority unless debug is starved.
    always_comb begin
        core_acc = 1'b0;
        dbg_acc = 1'b0;
        if (rst_n && state == S_DBG && dbg_req && dbg_lock)
            dbg_acc = 1'b1;
        else if (rst_n) begin
            dbg_acc = dbg_req && (!core_req || force_dbg);
            core_acc = core_req && !dbg_acc;
        end
        state_nxt = (dbg_acc && dbg_lock) ? S_DBG : S_CORE;
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_CORE;
            core_rd <= 1'b0;
            dbg_rd <= 1'b0;
        end else begin
            state <= state_nxt;
            core_rd <= core_acc && !core_we;
            dbg_rd <= dbg_acc && !dbg_we;
        end
    end
    assign mem_en = core_acc || dbg_acc;
    assign mem_we = (core_acc && core_we) || (dbg_acc && dbg_we);
    assign mem_addr = dbg_acc ? dbg_addr : core_addr;
    assign mem_wdata = dbg_acc ? dbg_wdata : core_wdata;
    assign core_stall = core_req && !core_acc;
    assign dbg_gnt = dbg_acc;
    // Masking with rst_n drops a read that was accepted just before reset asserted.
    assign core_rvalid = core_rd && rst_n;
    assign dbg_rvalid = dbg_rd && rst_n;
    assign core_rdata = mem_rdata;
    assign dbg_rdata = mem_rdata;
endmodule
